alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Two-stage pipelined wrapper that sits directly upstream of the 32-bit ALU and also captures the ALU's output.
- Stage 1 accepts operands and a 4-bit ALU control code through a valid/ready handshake, decodes the code into invertA/invertB/operation, and drives the registered operands and controls onto the ALU's input ports.
- Stage 2 registers the ALU's combinational result/zero/overflow one cycle later and presents them downstream with valid/ready.
- The block keeps a saturating count of overflowing results.

Parameters:
- DATA_W, 32, operand/result width; fixed to match the ALU.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream has an operation.
- in_ready  output  1  stage 1 can accept this cycle.
- in_a  input  DATA_W  source operand 1.
- in_b  input  DATA_W  source operand 2.
- in_ctrl  input  4  ALU control code.
- alu_src1  output  DATA_W  to ALU aluSrc1.
- alu_src2  output  DATA_W  to ALU aluSrc2.
- alu_invert_a  output  1  to ALU invertA.
- alu_invert_b  output  1  to ALU invertB.
- alu_operation  output  2  to ALU operation.
- alu_result  input  DATA_W  from ALU result.
- alu_zero  input  1  from ALU zero.
- alu_overflow  input  1  from ALU overflow.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- out_result  output  DATA_W  registered result.
- out_zero  output  1  registered zero flag.
- out_overflow  output  1  registered overflow, masked as described under Behaviour.
- out_err  output  1  the op carried an illegal ctrl code.
- ovf_count  output  CNT_W  number of overflow results delivered, saturating.

Behaviour:
- Reset (synchronous, active-high): s1_valid=0, s2_valid=0, all alu_* outputs=0, all out_* outputs=0, ovf_count=0. Any in-flight operation is dropped with no output. in_ready=1 on the first cycle after rst deasserts.
- Decode of in_ctrl to {invert_a, invert_b, operation}:
  - 0000 AND -> {0,0,00}
  - 0001 OR -> {0,0,01}
  - 0010 ADD -> {0,0,10}
  - 0110 SUB -> {0,1,10}
  - 0111 SLT -> {0,1,11}
  - 1100 NOR -> {1,1,00}
  - 1101 NAND -> {1,1,01}
  - Any other code: decode as ADD, set s1_err=1.
- Stage 1 register holds a, b, decoded controls, err, and an is_arith bit (ADD or SUB). Its a, b and controls drive alu_* directly.
- s1_adv = s1_valid & (~s2_valid | out_ready).
- in_ready = ~s1_valid | s1_adv. This is combinational and has no dependence on in_valid.
- Stage 1 loads when in_valid & in_ready. If it does not load but s1_adv is true, s1_valid clears. When not loading, the alu_* values hold their last contents.
- Stage 2 loads on s1_adv, capturing:
  - alu_result and alu_zero as-is;
  - overflow = alu_overflow & s1_is_arith;
  - err = s1_err.
  If s2 does not load and out_valid & out_ready, s2_valid clears.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+1. Throughput is one operation per cycle when out_ready stays high.
- Backpressure: with out_ready=0, at most 2 operations are held, after which in_ready=0. Order is preserved. Held outputs are stable while out_valid & ~out_ready.
- Simultaneous accept and drain in one cycle: both occur, and no bubble is inserted.
- ovf_count increments on out_valid & out_ready & out_overflow. It saturates at all-ones and never wraps.
- The ALU's combinational outputs must settle within one clock period from the stage 1 registers.

Decomposition:
- Shared package alu_pkg:
  - ctrl code constants CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR, CTRL_NAND;
  - operation encodings OP_AND=00, OP_OR=01, OP_ADD=10, OP_LESS=11.
- One natural sub-module: alu_ctrl_decode, a combinational mapping from in_ctrl to {invert_a, invert_b, operation, is_arith, err}.
- The ALU itself is instantiated by the parent, not inside this block.
- The bench connects a behavioural 32-bit ALU model to the alu_* ports.

Test Plan:
- ADD a=7, b=5, out_ready=1 -> out_result=12 two cycles later, zero=0, overflow=0, err=0.
- SUB a=5, b=5 -> out_result=0, out_zero=1, alu_invert_b=1 and alu_operation=10 while the op is in stage 1.
- ADD 0x7FFFFFFF+1 -> out_result=0x80000000, out_overflow=1, ovf_count=1 after the handshake. An AND with the ALU model forcing overflow=1 -> out_overflow=0 and the count is unchanged.
- Backpressure: out_ready=0, issue ops with ctrl 0010 as A=1+1, B=2+2, C=3+3 -> in_ready=0 once A and B are held. Then out_ready=1 -> results 2, 4, 6 in order, and C is accepted the cycle in_ready rises.
- in_ctrl=1111, a=3, b=4 -> out_result=7, out_err=1. With ovf_count preset to all-ones by repeated overflow -> it stays saturated.
- rst asserted with both stages valid -> out_valid=0, in_ready=1, ovf_count=0 after the next edge. No stale result emerges after rst is released.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage: the 4-bit ALU control codes,
// the 2-bit operation select driven to the ALU, and the decoded-control
// record produced by alu_ctrl_decode.
// ---------------------------------------------------------------------------
package alu_pkg;

  // ALU control codes accepted on in_ctrl
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;

  // Operation select seen by the ALU result mux
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  // Decoded control bundle for one operation
  typedef struct packed {
    logic       invert_a;
    logic       invert_b;
    logic [1:0] operation;
    logic       is_arith;  // ADD or SUB: the only ops whose overflow is reported
    logic       err;       // control code was not one of the legal seven
  } alu_dec_t;

endpackage : alu_pkg

// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
// Combinational map from a 4-bit ALU control code to the ALU input controls.
// Illegal codes decode as ADD with err set so the op still flows through
// the pipeline and is flagged downstream.
// Ports:
//   ctrl_i  : 4-bit ALU control code
//   dec_o   : {invert_a, invert_b, operation, is_arith, err}
// ---------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [3:0] ctrl_i,
  output alu_dec_t   dec_o
);

  // Control-code decode table
  always_comb begin
    dec_o = '{invert_a: 1'b0, invert_b: 1'b0, operation: OP_ADD,
              is_arith: 1'b0, err: 1'b0};
    case (ctrl_i)
      CTRL_AND:  dec_o = '{1'b0, 1'b0, OP_AND,  1'b0, 1'b0};
      CTRL_OR:   dec_o = '{1'b0, 1'b0, OP_OR,   1'b0, 1'b0};
      CTRL_ADD:  dec_o = '{1'b0, 1'b0, OP_ADD,  1'b1, 1'b0};
      CTRL_SUB:  dec_o = '{1'b0, 1'b1, OP_ADD,  1'b1, 1'b0};
      CTRL_SLT:  dec_o = '{1'b0, 1'b1, OP_LESS, 1'b0, 1'b0};
      CTRL_NOR:  dec_o = '{1'b1, 1'b1, OP_AND,  1'b0, 1'b0};
      CTRL_NAND: dec_o = '{1'b1, 1'b1, OP_OR,   1'b0, 1'b0};
      // Illegal code: run it as a plain ADD but mark it. Not treated as
      // arithmetic, so any overflow it produces is masked.
      default:   dec_o = '{1'b0, 1'b0, OP_ADD,  1'b0, 1'b1};
    endcase
  end

endmodule : alu_ctrl_decode

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Two-stage pipeline wrapped around an external combinational 32-bit ALU.
// Stage 1 registers operands and decoded controls and drives them onto the
// ALU inputs; stage 2 captures the ALU result/zero/overflow one cycle later
// and offers it downstream. A saturating counter tallies delivered
// overflowing results.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready, in_a/in_b/in_ctrl : upstream request
//   alu_src1/alu_src2/alu_invert_a/alu_invert_b/alu_operation : to ALU
//   alu_result/alu_zero/alu_overflow : from ALU
//   out_valid/out_ready, out_result/out_zero/out_overflow/out_err : downstream
//   ovf_count                     : saturating count of delivered overflows
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [3:0]        in_ctrl,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_invert_a,
  output logic              alu_invert_b,
  output logic [1:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              out_err,
  output logic [CNT_W-1:0]  ovf_count
);

  alu_dec_t dec_s;

  logic              s1_valid_q,  s1_valid_d;
  logic [DATA_W-1:0] s1_a_q,      s1_a_d;
  logic [DATA_W-1:0] s1_b_q,      s1_b_d;
  alu_dec_t          s1_dec_q,    s1_dec_d;

  logic              s2_valid_q,  s2_valid_d;
  logic [DATA_W-1:0] s2_result_q, s2_result_d;
  logic              s2_zero_q,   s2_zero_d;
  logic              s2_ovf_q,    s2_ovf_d;
  logic              s2_err_q,    s2_err_d;

  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic s1_adv_s, s1_load_s, s2_drain_s;

  alu_ctrl_decode u_dec (
    .ctrl_i (in_ctrl),
    .dec_o  (dec_s)
  );

  // Handshake terms: stage 1 moves on when stage 2 is empty or draining,
  // and can accept whenever it is empty or moving on (no in_valid path).
  always_comb begin
    s1_adv_s   = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready   = ~s1_valid_q | s1_adv_s;
    s1_load_s  = in_valid & in_ready;
    s2_drain_s = s2_valid_q & out_ready;
  end

  // Stage 1 next state: load a new op, empty on advance, otherwise hold
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_dec_d   = s1_dec_q;
    if (s1_load_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_dec_d   = dec_s;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: capture ALU outputs on advance, empty on drain
  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_ovf_d    = s2_ovf_q;
    s2_err_d    = s2_err_q;
    if (s1_adv_s) begin
      s2_valid_d  = 1'b1;
      s2_result_d = alu_result;
      s2_zero_d   = alu_zero;
      s2_ovf_d    = alu_overflow & s1_dec_q.is_arith;
      s2_err_d    = s1_dec_q.err;
    end else if (s2_drain_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Overflow counter: count delivered overflows, stick at all-ones
  always_comb begin
    if (s2_drain_s && s2_ovf_q && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= {DATA_W{1'b0}};
      s1_b_q      <= {DATA_W{1'b0}};
      s1_dec_q    <= '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
      s2_valid_q  <= 1'b0;
      s2_result_q <= {DATA_W{1'b0}};
      s2_zero_q   <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_err_q    <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_dec_q    <= s1_dec_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_err_q    <= s2_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Every output except in_ready comes straight from a register
  always_comb begin
    alu_src1      = s1_a_q;
    alu_src2      = s1_b_q;
    alu_invert_a  = s1_dec_q.invert_a;
    alu_invert_b  = s1_dec_q.invert_b;
    alu_operation = s1_dec_q.operation;
    out_valid     = s2_valid_q;
    out_result    = s2_result_q;
    out_zero      = s2_zero_q;
    out_overflow  = s2_ovf_q;
    out_err       = s2_err_q;
    ovf_count     = cnt_q;
  end

endmodule : alu_issue_stage

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed bench for alu_issue_stage with a behavioural ALU on the alu_*
// ports. A narrow counter width keeps the saturation case short.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_a, in_b;
  logic [3:0]    in_ctrl;
  logic [DW-1:0] alu_src1, alu_src2, alu_result;
  logic          alu_invert_a, alu_invert_b, alu_zero, alu_overflow;
  logic [1:0]    alu_operation;
  logic          out_valid, out_ready, out_zero, out_overflow, out_err;
  logic [DW-1:0] out_result;
  logic [CW-1:0] ovf_count;
  logic          force_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_invert_a(alu_invert_a), .alu_invert_b(alu_invert_b),
    .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_overflow(out_overflow), .out_err(out_err),
    .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: invert, add with carry-in = invertB, select by operation
  logic [DW-1:0] ma, mb, msum;
  logic          movf;
  always_comb begin
    ma   = alu_invert_a ? ~alu_src1 : alu_src1;
    mb   = alu_invert_b ? ~alu_src2 : alu_src2;
    msum = ma + mb + {31'd0, alu_invert_b};
    movf = (ma[DW-1] == mb[DW-1]) && (msum[DW-1] != ma[DW-1]);
    case (alu_operation)
      2'b00:   alu_result = ma & mb;
      2'b01:   alu_result = ma | mb;
      2'b10:   alu_result = msum;
      default: alu_result = {31'd0, msum[DW-1] ^ movf};
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_overflow = movf | force_ovf;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic        fovf;
    logic [31:0] res;
    logic        zero, ovf, err, inv_a, inv_b;
    logic [1:0]  op;
    logic [3:0]  cnt;   // ovf_count after this op drains
  } vec_t;

  vec_t vecs[10];

  initial begin
    //            ctrl     a             b             fo    result        z     o     e     ia    ib    op     cnt
    vecs[0] = '{4'b0010, 32'd7,        32'd5,        1'b0, 32'd12,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'd0};
    vecs[1] = '{4'b0110, 32'd5,        32'd5,        1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'd0};
    vecs[2] = '{4'b0010, 32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 4'd1};
    vecs[3] = '{4'b0000, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 32'h0F0F0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1};
    vecs[4] = '{4'b0001, 32'h000000F0, 32'h00000F00, 1'b0, 32'h00000FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'd1};
    vecs[5] = '{4'b0111, 32'd3,        32'd5,        1'b0, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 4'd1};
    vecs[6] = '{4'b1100, 32'h0000000F, 32'h000000F0, 1'b0, 32'hFFFFFF00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 4'd1};
    vecs[7] = '{4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 4'd1};
    vecs[8] = '{4'b1111, 32'd3,        32'd4,        1'b0, 32'd7,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'd1};
    vecs[9] = '{4'b0110, 32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 4'd2};

    rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_ctrl = 4'd0;
    out_ready = 1'b1; force_ovf = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ovf_count", {28'd0, ovf_count}, 32'd0);
    chk("rst_alu_src1",  alu_src1,           32'd0);
    chk("rst_alu_op",    {30'd0, alu_operation}, 32'd0);
    chk("rst_out_result", out_result,        32'd0);

    // Table: one op at a time, out_ready held high
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b; in_ctrl = vecs[i].ctrl;
      force_ovf = vecs[i].fovf;
      chk("in_ready", {31'd0, in_ready}, 32'd1);
      tick();                       // accepted into stage 1
      in_valid = 1'b0;
      chk("alu_src1",     alu_src1,                  vecs[i].a);
      chk("alu_invert_a", {31'd0, alu_invert_a},     {31'd0, vecs[i].inv_a});
      chk("alu_invert_b", {31'd0, alu_invert_b},     {31'd0, vecs[i].inv_b});
      chk("alu_operation", {30'd0, alu_operation},   {30'd0, vecs[i].op});
      tick();                       // captured into stage 2
      chk("out_valid",    {31'd0, out_valid},        32'd1);
      chk("out_result",   out_result,                vecs[i].res);
      chk("out_zero",     {31'd0, out_zero},         {31'd0, vecs[i].zero});
      chk("out_overflow", {31'd0, out_overflow},     {31'd0, vecs[i].ovf});
      chk("out_err",      {31'd0, out_err},          {31'd0, vecs[i].err});
      tick();                       // drained
      force_ovf = 1'b0;
      chk("drained",      {31'd0, out_valid},        32'd0);
      chk("ovf_count",    {28'd0, ovf_count},        {28'd0, vecs[i].cnt});
    end

    // Backpressure: A=1+1, B=2+2 fill the pipe, C waits for in_ready
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'b0010; in_a = 32'd1; in_b = 32'd1;
    tick();
    chk("bp_ready_after_A", {31'd0, in_ready}, 32'd1);
    in_a = 32'd2; in_b = 32'd2;
    tick();
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    chk("bp_valid_A",    {31'd0, out_valid}, 32'd1);
    chk("bp_result_A",   out_result, 32'd2);
    in_a = 32'd3; in_b = 32'd3;
    tick();
    tick();
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_A",     out_result, 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_rise", {31'd0, in_ready}, 32'd1);
    tick();                          // A drains, B to stage 2, C accepted
    in_valid = 1'b0;
    chk("bp_result_B", out_result, 32'd4);
    chk("bp_valid_B",  {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_result_C", out_result, 32'd6);
    chk("bp_valid_C",  {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_empty",    {31'd0, out_valid}, 32'd0);
    chk("bp_count",    {28'd0, ovf_count}, 32'd2);

    // Illegal code, back-to-back overflowing ADDs drive the counter to saturation
    in_valid = 1'b1; in_ctrl = 4'b0010; in_a = 32'h7FFFFFFF; in_b = 32'd1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i >= 1) chk("stream_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat_count", {28'd0, ovf_count}, 32'd15);
    in_valid = 1'b1; in_ctrl = 4'b1111; in_a = 32'd3; in_b = 32'd4;
    tick();
    in_valid = 1'b0;
    tick();
    chk("err_result", out_result, 32'd7);
    chk("err_flag",   {31'd0, out_err}, 32'd1);
    tick();
    chk("sat_hold",   {28'd0, ovf_count}, 32'd15);

    // Reset with both stages occupied
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'b0010; in_a = 32'd9; in_b = 32'd9;
    tick();
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready},  32'd1);
    chk("mid_rst_count", {28'd0, ovf_count}, 32'd0);
    chk("mid_rst_result", out_result, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_issue_stage
